// File: rtl/clk_freq_duty_meter_if.sv
// ----------------------------------------------------------------------------
// clk_freq_duty_meter_if
//   Request/result bundle of the clock frequency / duty meter.
//   master : the requester (drives start, observes status and results)
//   slave  : the meter itself
// Signals:
//   start       request a measurement (single cycle, ignored while busy)
//   busy        measurement in progress
//   valid       one-cycle pulse, results updated in the same cycle
//   timeout     one-cycle pulse, measurement aborted, results unchanged
//   period_cnt  clk cycles between two detected rising edges
//   high_cnt    clk cycles from detected rising to detected falling edge
//   duty_pct    floor(100*high/period), only with CLK_METER_DUTY_PCT_EN
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface clk_freq_duty_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
`ifdef CLK_METER_DUTY_PCT_EN
  logic [6:0]       duty_pct;

  modport master (
    output start,
    input  busy, valid, timeout, period_cnt, high_cnt, duty_pct
  );
  modport slave (
    input  start,
    output busy, valid, timeout, period_cnt, high_cnt, duty_pct
  );
`else
  modport master (
    output start,
    input  busy, valid, timeout, period_cnt, high_cnt
  );
  modport slave (
    input  start,
    output busy, valid, timeout, period_cnt, high_cnt
  );
`endif
endinterface

// File: rtl/clk_freq_duty_meter.sv
// ----------------------------------------------------------------------------
// clk_freq_duty_meter
//   Measures period and high time of an asynchronous signal (sig_in) in
//   reference clock cycles. sig_in goes through a SYNC_STAGES flop
//   synchronizer plus one history flop; rising/falling edges are taken from
//   the last sync flop against the history flop. The fixed detection latency
//   cancels out of both differences.
//
//   Optional feature (macro CLK_METER_DUTY_PCT_EN): adds duty_pct computed
//   by a 7-step restoring divider after the final edge; valid is then
//   delayed until the division is done.
//
// Ports:
//   clk     reference clock, rising edge
//   rst     synchronous active-high reset
//   sig_in  signal under measurement, asynchronous to clk
//   bus     slave side of clk_freq_duty_meter_if (start/busy/valid/timeout/
//           period_cnt/high_cnt[/duty_pct])
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module clk_freq_duty_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sig_in,
  clk_freq_duty_meter_if.slave  bus
);

  // Watchdog fires when the count reaches TIMEOUT_CYC-1 so the abort pulse
  // is visible exactly TIMEOUT_CYC cycles after the state was entered.
  localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(TIMEOUT_CYC - 1);

`ifdef CLK_METER_DUTY_PCT_EN
  localparam int DIV_W = CNT_W + 7;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
`ifdef CLK_METER_DUTY_PCT_EN
    S_LOW,
    S_DIV
`else
    S_LOW
`endif
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_sync;
  logic                   w_rise;
  logic                   w_fall;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_wd;
  logic [CNT_W-1:0]       r_high_tmp;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   w_wd_hit;
  logic                   w_arm_rise;
  logic                   w_cap_high;
  logic                   w_done;
  logic                   w_abort;

`ifdef CLK_METER_DUTY_PCT_EN
  logic [CNT_W-1:0]       r_period_tmp;
  logic [DIV_W-1:0]       r_num;
  logic [DIV_W-1:0]       r_den;
  logic [6:0]             r_q;
  logic [2:0]             r_div_cnt;
  logic [6:0]             r_duty;
  logic                   w_div_last;
  logic                   w_ge;
`endif

  // Synchronizer and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_sync & ~r_hist;
  assign w_fall   = ~w_sync & r_hist;
  assign w_wd_hit = (r_wd == WD_LIM);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and strobes; watchdog abort takes priority over edges
  always_comb begin
    w_state_nxt = r_state;
    w_arm_rise  = 1'b0;
    w_cap_high  = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
`ifdef CLK_METER_DUTY_PCT_EN
    w_div_last  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (w_wd_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rise) begin
          w_arm_rise  = 1'b1;
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_wd_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_fall) begin
          w_cap_high  = 1'b1;
          w_state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (w_wd_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rise) begin
          w_done      = 1'b1;
`ifdef CLK_METER_DUTY_PCT_EN
          w_state_nxt = S_DIV;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef CLK_METER_DUTY_PCT_EN
      S_DIV: begin
        if (r_div_cnt == 3'd6) begin
          w_div_last  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters, captures and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_wd       <= '0;
      r_high_tmp <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= w_abort;
      r_wd      <= (w_state_nxt != r_state) ? '0 : sat_inc(r_wd);
      if (w_arm_rise)
        r_cnt <= CNT_W'(1);
      else if (r_state == S_HIGH || r_state == S_LOW)
        r_cnt <= sat_inc(r_cnt);
      if (w_cap_high) r_high_tmp <= r_cnt;
`ifndef CLK_METER_DUTY_PCT_EN
      if (w_done) begin
        r_period <= r_cnt;
        r_high   <= r_high_tmp;
        r_valid  <= 1'b1;
      end
`else
      if (w_div_last) begin
        r_period <= r_period_tmp;
        r_high   <= r_high_tmp;
        r_valid  <= 1'b1;
      end
`endif
    end
  end

`ifdef CLK_METER_DUTY_PCT_EN
  // Restoring divider: quotient < 100 fits 7 bits, so the divisor starts
  // shifted left by 6 and one quotient bit is resolved per DIV cycle.
  assign w_ge = (r_num >= r_den);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_tmp <= '0;
      r_num        <= '0;
      r_den        <= '0;
      r_q          <= '0;
      r_div_cnt    <= '0;
      r_duty       <= '0;
    end else if (w_done) begin
      r_period_tmp <= r_cnt;
      r_num        <= DIV_W'(r_high_tmp) * DIV_W'(100);
      r_den        <= DIV_W'(r_cnt) << 6;
      r_q          <= '0;
      r_div_cnt    <= '0;
    end else if (r_state == S_DIV) begin
      r_num     <= w_ge ? (r_num - r_den) : r_num;
      r_den     <= r_den >> 1;
      r_q       <= {r_q[5:0], w_ge};
      r_div_cnt <= r_div_cnt + 3'd1;
      if (w_div_last) r_duty <= {r_q[5:0], w_ge};
    end
  end

  assign bus.duty_pct = r_duty;
`endif

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.valid      = r_valid;
  assign bus.timeout    = r_timeout;
  assign bus.period_cnt = r_period;
  assign bus.high_cnt   = r_high;

endmodule

// File: tb/tb_clk_freq_duty_meter.sv
`timescale 1ns/1ps
module tb_clk_freq_duty_meter;
  localparam int CNT_W = 16;
  localparam int TO    = 1000;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic sig_in = 1'b0;

  clk_freq_duty_meter_if #(.CNT_W(CNT_W)) bus ();

  clk_freq_duty_meter #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sig_in(sig_in),
    .bus(bus)
  );

  // 1 ns reference clock, rising edges at n+0.5 ns
  always #0.5 clk = ~clk;

  // Signal generator: edges on whole ns, half a clock away from clk edges,
  // so a pattern of gen_p ns period / gen_h ns high is exactly gen_p / gen_h
  // reference cycles.
  int   gen_p   = 10;
  int   gen_h   = 4;
  bit   gen_en  = 1'b0;
  logic gen_lvl = 1'b0;

  always begin
    if (gen_en) begin
      sig_in = 1'b1;
      #(gen_h);
      sig_in = 1'b0;
      #(gen_p - gen_h);
    end else begin
      sig_in = gen_lvl;
      #1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // kind: 0 = bound expired, 1 = valid, 2 = timeout; n = negedge index
  task automatic wait_end(input int budget, output int kind, output int n);
    kind = 0;
    n    = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.valid)   begin kind = 1; n = i; break; end
      if (bus.timeout) begin kind = 2; n = i; break; end
    end
  endtask

  task automatic measure(input string tag, input int p, input int h);
    int kind, n;
    wait_end(400, kind, n);
    check({tag, "_valid"}, kind, 1);
    check({tag, "_period"}, bus.period_cnt, p);
    check({tag, "_high"}, bus.high_cnt, h);
    check({tag, "_busy_at_valid"}, bus.busy, 0);
`ifdef CLK_METER_DUTY_PCT_EN
    check({tag, "_duty"}, bus.duty_pct, (100 * h) / p);
`endif
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, bus.valid, 0);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_period"}, bus.period_cnt, 0);
    check({tag, "_high"}, bus.high_cnt, 0);
  endtask

  initial begin
    int kind, n, p, h, ev;
    bus.start = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    reset_outputs("reset");
    rst = 1'b0;

    // 100 MHz / 40 %
    gen_p = 10; gen_h = 4; gen_en = 1'b1;
    repeat (30) @(negedge clk);
    do_start();
    check("t1_busy_after_start", bus.busy, 1);
    measure("t1", 10, 4);

    // 50 MHz / 50 %, back to back, extra start while busy
    gen_en = 1'b0; gen_lvl = 1'b0;
    repeat (30) @(negedge clk);
    gen_p = 20; gen_h = 10; gen_en = 1'b1;
    repeat (5) @(negedge clk);
    do_start();
    repeat (3) @(negedge clk);
    check("t2_busy_mid", bus.busy, 1);
    do_start();
    measure("t2a", 20, 10);
    ev = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.busy || bus.valid) ev++;
    end
    check("t2_no_extra_measurement", ev, 0);
    do_start();
    measure("t2b", 20, 10);

    // Level already high at start is not a rise
    gen_en = 1'b0; gen_lvl = 1'b1;
    repeat (40) @(negedge clk);
    gen_p = 10; gen_h = 4;
    do_start();
    repeat (3) @(negedge clk);
    gen_en = 1'b1;
    measure("t3", 10, 4);

    // Stuck low -> timeout after TO cycles, results untouched
    gen_en = 1'b0; gen_lvl = 1'b0;
    repeat (30) @(negedge clk);
    do_start();
    wait_end(TO + 100, kind, n);
    check("t4_timeout_seen", kind, 2);
    check("t4_timeout_latency", n + 1, TO);
    check("t4_busy_at_timeout", bus.busy, 0);
    check("t4_period_held", bus.period_cnt, 10);
    check("t4_high_held", bus.high_cnt, 4);
    @(negedge clk);
    check("t4_timeout_one_cycle", bus.timeout, 0);

    // Reset while in HIGH, then a fresh measurement
    gen_p = 40; gen_h = 30;
    do_start();
    gen_en = 1'b1;
    @(posedge sig_in);
    repeat (8) @(negedge clk);
    check("t5_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_outputs("t5_rst");
    ev = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy || bus.valid || bus.timeout) ev++;
    end
    check("t5_quiet_after_rst", ev, 0);
    do_start();
    measure("t5", 40, 30);

`ifdef CLK_METER_DUTY_PCT_EN
    // period 7 / high 3 -> 42 %
    gen_en = 1'b0; gen_lvl = 1'b0;
    repeat (50) @(negedge clk);
    gen_p = 7; gen_h = 3; gen_en = 1'b1;
    repeat (3) @(negedge clk);
    do_start();
    measure("t6", 7, 3);
`endif

    // Randomized periods / high times against the reference arithmetic
    for (int it = 0; it < 8; it++) begin
      gen_en = 1'b0; gen_lvl = 1'b0;
      repeat (50) @(negedge clk);
      p = int'($urandom_range(40, 2));
      h = int'($urandom_range(p - 1, 1));
      gen_p = p; gen_h = h; gen_en = 1'b1;
      repeat (3) @(negedge clk);
      do_start();
      measure($sformatf("rnd%0d_p%0d_h%0d", it, p, h), p, h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #60000;
    $display("FAIL global_timeout: observed=stuck required=finish");
    $fatal(1, "simulation bound exceeded");
  end

endmodule

// File: doc/clk_freq_duty_meter.md
Name: clk_freq_duty_meter

Overview:
- Synthesizable measurement stage that consumes a generated clock (e.g. a 100 MHz / 40 % test clock) and reports its period and high time in reference-clock cycles.
- Sits directly downstream of the clock-generation stage, so benches and self-checks can confirm frequency and duty cycle numerically instead of by waveform inspection.
- `sig_in` is asynchronous to `clk` and is synchronized internally.

Parameters:
- CNT_W, 16, width of the period/high counters and result outputs.
- SYNC_STAGES, 2, number of flops in the `sig_in` synchronizer (legal values >= 2).
- TIMEOUT_CYC, 1000, max `clk` cycles allowed between expected edges before abort; must be <= 2^CNT_W-1.

Ports:
- clk  input  1  reference sampling clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  clock/signal under measurement, asynchronous.
- start  input  1  one-cycle request to begin a measurement; ignored while busy=1.
- busy  output  1  high from the cycle after accepted start until the cycle valid or timeout pulses.
- valid  output  1  one-cycle pulse; period_cnt/high_cnt updated in the same cycle.
- timeout  output  1  one-cycle pulse on abort; results not updated.
- period_cnt  output  CNT_W  clk cycles between two successive detected rising edges.
- high_cnt  output  CNT_W  clk cycles from detected rising edge to detected falling edge.

Behaviour:
- Reset, synchronous with rst=1 at a clk edge: FSM returns to IDLE. busy, valid, timeout, period_cnt, high_cnt, synchronizer flops, edge-history flop and all counters all go to 0. Reset mid-measurement aborts with no valid and no timeout pulse.
- Synchronizer: SYNC_STAGES flops followed by one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Detection latency is a fixed SYNC_STAGES+1 cycles, so it cancels out of all differences.
- Result definition: with detected edges at cycles r1 (rise), f1 (fall) and r2 (next rise), period_cnt = r2-r1 and high_cnt = f1-r1.
- FSM states: IDLE, ARM, HIGH, LOW, (DIV, only with the optional feature).
  - IDLE: start=1 -> ARM, busy=1 next cycle.
  - ARM: waits for a rise. On rise: cnt cleared to 1 -> HIGH. A level already high at start is not a rise; ARM waits for the next genuine edge.
  - HIGH: cnt increments each cycle. On fall: capture high = cnt -> LOW.
  - LOW: cnt increments each cycle. On rise: capture period = cnt, update outputs, pulse valid, drop busy in the same cycle -> IDLE.
- Counter: cnt saturates at 2^CNT_W-1 and never wraps.
- Watchdog: separate counter, cleared on every state entry. If it reaches TIMEOUT_CYC in ARM, HIGH or LOW:
  - timeout pulses for one cycle and busy drops in that cycle;
  - FSM -> IDLE;
  - period_cnt/high_cnt keep their previous values.
- Simultaneous events: start asserted in the same cycle valid/timeout pulses is ignored (FSM not yet IDLE). start is accepted only in IDLE.
- Results hold their values until the next valid or rst.
- Glitch handling: none. Pulses shorter than one clk period may be missed; this is the caller's responsibility.

Optional Feature:
- Macro: CLK_METER_DUTY_PCT_EN.
- When defined:
  - Adds output port `duty_pct` (7 bits, reset 0) = floor(100*high_cnt/period_cnt).
  - Computed by a sequential restoring divider in state DIV, entered instead of IDLE on the final rise. DIV lasts exactly 7 cycles.
  - valid, result update and busy deassertion then occur on the cycle after DIV completes (8 cycles after r2 detection).
  - period_cnt==0 cannot occur, since the minimum value is 2.
- When not defined: the port is absent, there is no DIV state, and valid occurs in the r2 detection cycle.

Test Plan:
- clk 1 ns period, sig_in 100 MHz / 40 % with edges offset 0.5 ns from clk, start pulse -> single valid pulse, period_cnt=10, high_cnt=4 (duty_pct=40 with feature).
- sig_in 50 MHz / 50 %, two back-to-back measurements -> both valid, period_cnt=20, high_cnt=10. A start asserted during busy produces no extra measurement.
- sig_in held high before start, then toggling at 10 ns / 4 ns high -> ARM ignores the initial level and reports period_cnt=10, high_cnt=4.
- sig_in stuck at 0, TIMEOUT_CYC=1000 -> timeout pulses exactly 1000 cycles after ARM entry; busy=0 that cycle; prior results unchanged.
- rst asserted while in HIGH -> all outputs 0 next cycle, no valid/timeout. A subsequent start measures correctly.
- With CLK_METER_DUTY_PCT_EN, period 7 / high 3 -> duty_pct=42; valid lands 8 cycles after r2 detection.
